// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: data/field widths, opcode and
// FSM state encodings, instruction layout and opcode classification helpers.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 3;
  localparam int INSTR_W = OPC_W + 2 * REG_W;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SHL  = 4'b0001,
    OP_SHR  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_ADDI = 4'b0110,
    OP_MOV  = 4'b0111,
    OP_BNE  = 4'b1000,
    OP_BEQ  = 4'b1001,
    OP_MOVI = 4'b1010,
    OP_CMP  = 4'b1101,
    OP_NOP  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } ctrl_state_e;

  // [9:6] opcode, [5:3] rd, [2:0] rs or imm3
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
  } instr_t;

  // 1011, 1100 and 1110 have no defined behaviour
  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      4'b1011, 4'b1100, 4'b1110: legal = 1'b0;
      default:                   legal = 1'b1;
    endcase
    return legal;
  endfunction

  // Opcodes whose result lands in R[rd]
  function automatic logic op_writes(input logic [OPC_W-1:0] op);
    return (op <= 4'b0111) || (op == OP_MOVI);
  endfunction

  // Writers plus CMP refresh the zero/parity/equal flags
  function automatic logic op_sets_flags(input logic [OPC_W-1:0] op);
    return op_writes(op) || (op == OP_CMP);
  endfunction

  // Only the shifts consume and produce the carry
  function automatic logic op_is_shift(input logic [OPC_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic op_is_branch(input logic [OPC_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake plus ALU drive/response bundle for alu_ctrl.
// master: instruction issuer and ALU side; slave: the controller.
interface alu_ctrl_if;
  import alu_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;

  logic [OPC_W-1:0]   alu_cmd;
  logic [DATA_W-1:0]  alu_inA;
  logic [DATA_W-1:0]  alu_inB;
  logic               alu_sc_i;

  logic [DATA_W-1:0]  alu_rslt;
  logic               alu_sc_o;
  logic               alu_pari;
  logic               alu_zero;
  logic               alu_equal;

  modport master (
    output instr_valid, instr,
    output alu_rslt, alu_sc_o, alu_pari, alu_zero, alu_equal,
    input  instr_ready,
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i
  );

  modport slave (
    input  instr_valid, instr,
    input  alu_rslt, alu_sc_o, alu_pari, alu_zero, alu_equal,
    output instr_ready,
    output alu_cmd, alu_inA, alu_inB, alu_sc_i
  );

endinterface

// File: rtl/alu_ctrl_reg_file.sv
// reg_file: NREGS x DATA_W register file, async reset, one write port, two
// operand read ports and a debug tap. Reads are combinational; addresses at
// or beyond NREGS read as zero and are never written.
module reg_file #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] mem [NREGS];

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(gi);
      logic [DATA_W-1:0] q_reg;

      // One storage register per entry, loaded when addressed by the write port
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == MY_ADDR)) begin
          q_reg <= wdata;
        end
      end

      assign mem[gi] = q_reg;
    end
  endgenerate

  assign rdata_a  = (int'(raddr_a)  < NREGS) ? mem[raddr_a[IDX_W-1:0]]  : '0;
  assign rdata_b  = (int'(raddr_b)  < NREGS) ? mem[raddr_b[IDX_W-1:0]]  : '0;
  assign dbg_data = (int'(dbg_addr) < NREGS) ? mem[dbg_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE/EXEC/WB) sequencer around an external
// combinational ALU. Latches one instruction, drives the ALU in EXEC,
// captures its response, then writes back and updates flags in WB.
// Optional build macro ALU_CTRL_TRAP_EN: illegal opcodes raise a sticky trap
// that blocks further instructions until reset; without it they act as NOP.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_ctrl_if.slave         bus,
  output logic              done,
  output logic              br_valid,
  output logic              br_taken,
  output logic              eq_flag,
  output logic              zero_flag,
  output logic              pari_flag,
  output logic              carry_flag,
  input  logic [REG_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              trap
);

  ctrl_state_e state_reg, state_next;
  instr_t      instr_reg;

  // ALU response held from the end of EXEC so WB never sees a live ALU
  logic [DATA_W-1:0] rslt_reg;
  logic              sc_reg, pari_reg, zero_reg, equal_reg;

  logic eq_flag_reg, zero_flag_reg, pari_flag_reg, carry_flag_reg;
  logic trap_reg;

  logic [DATA_W-1:0] rd_data, rs_data, imm_ext;
  logic              wr_en, accept;
  logic              instr_ready_c;
  logic [OPC_W-1:0]  alu_cmd_c;
  logic [DATA_W-1:0] alu_ina_c, alu_inb_c;
  logic              alu_sci_c;

  assign imm_ext = {{(DATA_W-REG_W){1'b0}}, instr_reg.rs};
  assign accept  = (state_reg == ST_IDLE) && bus.instr_valid && instr_ready_c;

  reg_file #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W),
    .ADDR_W (REG_W)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (instr_reg.rd),
    .wdata    (rslt_reg),
    .raddr_a  (instr_reg.rd),
    .raddr_b  (instr_reg.rs),
    .dbg_addr (dbg_addr),
    .rdata_a  (rd_data),
    .rdata_b  (rs_data),
    .dbg_data (dbg_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, ALU drive, write enable and completion/branch pulses
  always_comb begin
    state_next    = state_reg;
    instr_ready_c = 1'b0;
    alu_cmd_c     = OP_NOP;
    alu_ina_c     = '0;
    alu_inb_c     = '0;
    alu_sci_c     = 1'b0;
    wr_en         = 1'b0;
    done          = 1'b0;
    br_valid      = 1'b0;
    br_taken      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        instr_ready_c = !trap_reg;
        if (bus.instr_valid && instr_ready_c) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_cmd_c = instr_reg.opcode;
        alu_ina_c = rd_data;
        alu_inb_c = rs_data;
        case (instr_reg.opcode)
          OP_MOV:  alu_ina_c = rs_data;
          OP_ADDI: alu_inb_c = imm_ext;
          OP_MOVI: begin
            alu_ina_c = imm_ext;
            alu_inb_c = '0;
          end
          default: ;
        endcase
        if (op_is_shift(instr_reg.opcode)) begin
          alu_sci_c = carry_flag_reg;
        end
        state_next = ST_WB;
      end
      ST_WB: begin
        done  = 1'b1;
        wr_en = op_writes(instr_reg.opcode);
        if (op_is_branch(instr_reg.opcode)) begin
          br_valid = 1'b1;
          br_taken = (instr_reg.opcode == OP_BEQ) ? equal_reg : !equal_reg;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the instruction on the handshake so the issuer may change it afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= '0;
    end else if (accept) begin
      instr_reg <= bus.instr;
    end
  end

  // Capture the combinational ALU response at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt_reg  <= '0;
      sc_reg    <= 1'b0;
      pari_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      equal_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      rslt_reg  <= bus.alu_rslt;
      sc_reg    <= bus.alu_sc_o;
      pari_reg  <= bus.alu_pari;
      zero_reg  <= bus.alu_zero;
      equal_reg <= bus.alu_equal;
    end
  end

  // Status flags follow the captured response at the end of WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_flag_reg    <= 1'b0;
      zero_flag_reg  <= 1'b0;
      pari_flag_reg  <= 1'b0;
      carry_flag_reg <= 1'b0;
    end else if (state_reg == ST_WB) begin
      if (op_sets_flags(instr_reg.opcode)) begin
        eq_flag_reg   <= equal_reg;
        zero_flag_reg <= zero_reg;
        pari_flag_reg <= pari_reg;
      end
      if (op_is_shift(instr_reg.opcode)) begin
        carry_flag_reg <= sc_reg;
      end
    end
  end

`ifdef ALU_CTRL_TRAP_EN
  // Sticky trap, raised entering WB of an illegal opcode, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_reg <= 1'b0;
    end else if ((state_reg == ST_EXEC) && !op_is_legal(instr_reg.opcode)) begin
      trap_reg <= 1'b1;
    end
  end
`else
  assign trap_reg = 1'b0;
`endif

  assign bus.instr_ready = instr_ready_c;
  assign bus.alu_cmd     = alu_cmd_c;
  assign bus.alu_inA     = alu_ina_c;
  assign bus.alu_inB     = alu_inb_c;
  assign bus.alu_sc_i    = alu_sci_c;

  assign eq_flag    = eq_flag_reg;
  assign zero_flag  = zero_flag_reg;
  assign pari_flag  = pari_flag_reg;
  assign carry_flag = carry_flag_reg;
  assign trap       = trap_reg;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a behavioural ALU answers the controller,
// and an architectural model (register array + flags) predicts every
// instruction's ALU drive, pulses, flags and register contents.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int NREGS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done, br_valid, br_taken;
  logic       eq_flag, zero_flag, pari_flag, carry_flag, trap;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [NREGS];
  logic       m_z, m_p, m_e, m_c, m_trap;

  alu_ctrl_if bus ();

  alu_ctrl #(.NREGS(NREGS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .done       (done),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .eq_flag    (eq_flag),
    .zero_flag  (zero_flag),
    .pari_flag  (pari_flag),
    .carry_flag (carry_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .trap       (trap)
  );

  always #10 clk = ~clk;

  // Behavioural ALU: {carry_out, result}
  function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] a,
                                       input logic [7:0] b, input logic sci);
    logic [8:0] r;
    case (c)
      4'b0000, 4'b0110:                   r = {1'b0, a} + {1'b0, b};
      4'b0001:                            r = {a[7], (a << b[2:0]) | {7'b0, sci}};
      4'b0010:                            r = {a[0], (a >> b[2:0]) | {sci, 7'b0}};
      4'b0011, 4'b1000, 4'b1001, 4'b1101: r = {1'b0, a} - {1'b0, b};
      4'b0100:                            r = {1'b0, a & b};
      4'b0101:                            r = {1'b0, a | b};
      4'b0111, 4'b1010:                   r = {1'b0, a};
      default:                            r = 9'h000;
    endcase
    return r;
  endfunction

  logic [8:0] alu_out;
  assign alu_out       = alu_f(bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i);
  assign bus.alu_rslt  = alu_out[7:0];
  assign bus.alu_sc_o  = alu_out[8];
  assign bus.alu_pari  = ^alu_out[7:0];
  assign bus.alu_zero  = (alu_out[7:0] == 8'h00);
  assign bus.alu_equal = (bus.alu_inA == bus.alu_inB);

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_z = 1'b0; m_p = 1'b0; m_e = 1'b0; m_c = 1'b0; m_trap = 1'b0;
  endtask

  // One instruction through accept, EXEC, WB and the following IDLE cycle
  task automatic exec_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    logic [7:0] a, b;
    logic       sci, eqv, legal, wr, fl, sh, brv, brt;
    logic [8:0] r;
    int         waitc;
    legal = !((op == 4'b1011) || (op == 4'b1100) || (op == 4'b1110));
    sh    = (op == OP_SHL) || (op == OP_SHR);
    a     = (op == OP_MOV) ? m_regs[rs] : (op == OP_MOVI) ? {5'b0, rs} : m_regs[rd];
    b     = (op == OP_ADDI) ? {5'b0, rs} : (op == OP_MOVI) ? 8'h00 : m_regs[rs];
    sci   = sh ? m_c : 1'b0;
    r     = alu_f(op, a, b, sci);
    eqv   = (a == b);
    wr    = (op <= 4'b0111) || (op == OP_MOVI);
    fl    = wr || (op == OP_CMP);
    brv   = (op == OP_BEQ) || (op == OP_BNE);
    brt   = brv && ((op == OP_BEQ) ? eqv : !eqv);

    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs};
    waitc = 0;
    while (!bus.instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout op=%b got ready=%b required 1", op, bus.instr_ready);
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 10'($urandom);

    @(negedge clk);  // EXEC
    checks++;
    if ({bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i, done, bus.instr_ready}
        !== {op, a, b, sci, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL exec_drive op=%b got cmd=%b A=%h B=%h sci=%b done=%b rdy=%b required cmd=%b A=%h B=%h sci=%b done=0 rdy=0",
               op, bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i, done, bus.instr_ready, op, a, b, sci);
    end

    @(negedge clk);  // WB
`ifdef ALU_CTRL_TRAP_EN
    if (!legal) m_trap = 1'b1;
`endif
    checks++;
    if ({done, br_valid, br_taken, bus.alu_cmd, bus.alu_inA, bus.alu_inB, trap}
        !== {1'b1, brv, brt, 4'hF, 16'h0000, m_trap}) begin
      failures++;
      $display("FAIL wb_pulse op=%b got done=%b brv=%b brt=%b cmd=%b A=%h B=%h trap=%b required done=1 brv=%b brt=%b cmd=1111 A=00 B=00 trap=%b",
               op, done, br_valid, br_taken, bus.alu_cmd, bus.alu_inA, bus.alu_inB, trap, brv, brt, m_trap);
    end
    if (wr) m_regs[rd] = r[7:0];
    if (fl) begin
      m_z = (r[7:0] == 8'h00);
      m_p = ^r[7:0];
      m_e = eqv;
    end
    if (sh) m_c = r[8];

    @(negedge clk);  // back in IDLE
    checks++;
    if ({eq_flag, zero_flag, pari_flag, carry_flag, bus.instr_ready, done, trap}
        !== {m_e, m_z, m_p, m_c, !m_trap, 1'b0, m_trap}) begin
      failures++;
      $display("FAIL idle_flags op=%b got eq=%b z=%b p=%b c=%b rdy=%b done=%b trap=%b required eq=%b z=%b p=%b c=%b rdy=%b done=0 trap=%b",
               op, eq_flag, zero_flag, pari_flag, carry_flag, bus.instr_ready, done, trap,
               m_e, m_z, m_p, m_c, !m_trap, m_trap);
    end
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== m_regs[i]) begin
        failures++;
        $display("FAIL reg_value op=%b r%0d got %h required %h", op, i, dbg_data, m_regs[i]);
      end
    end
    $display("txn op=%b rd=%0d rs=%0d A=%h B=%h rslt=%h br=%b/%b flags eq=%b z=%b p=%b c=%b",
             op, rd, rs, a, b, r[7:0], brv, brt, m_e, m_z, m_p, m_c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, done, br_valid, br_taken, bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i,
         eq_flag, zero_flag, pari_flag, carry_flag, trap}
        !== {1'b1, 3'b000, 4'hF, 16'h0000, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b done=%b brv=%b brt=%b cmd=%b A=%h B=%h sci=%b flags=%b%b%b%b trap=%b required rdy=1 cmd=1111 others 0",
               bus.instr_ready, done, br_valid, br_taken, bus.alu_cmd, bus.alu_inA, bus.alu_inB,
               bus.alu_sc_i, eq_flag, zero_flag, pari_flag, carry_flag, trap);
    end
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg r%0d got %h required 00", i, dbg_data);
      end
    end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_arith();
    exec_instr(OP_MOVI, 3'd1, 3'd3);
    exec_instr(OP_MOVI, 3'd2, 3'd2);
    exec_instr(OP_ADD,  3'd1, 3'd2);
    dbg_addr = 3'd1;
    #1;
    checks++;
    if ({dbg_data, zero_flag} !== {8'd5, 1'b0}) begin
      failures++;
      $display("FAIL add_r1 got r1=%h zero=%b required r1=05 zero=0", dbg_data, zero_flag);
    end
  endtask

  task automatic test_shift();
    exec_instr(OP_MOVI, 3'd3, 3'd4);
    exec_instr(OP_SHL,  3'd3, 3'd2);   // 4 << 2 with carry-in 0
    dbg_addr = 3'd3;
    #1;
    checks++;
    if ({dbg_data, carry_flag} !== {8'h10, 1'b0}) begin
      failures++;
      $display("FAIL shl_r3 got r3=%h carry=%b required r3=10 carry=0", dbg_data, carry_flag);
    end
    // Push a one out of bit 7 so the carry feeds a later shift
    exec_instr(OP_MOVI, 3'd6, 3'd1);
    exec_instr(OP_MOVI, 3'd7, 3'd7);
    exec_instr(OP_SHL,  3'd6, 3'd7);
    exec_instr(OP_SHL,  3'd6, 3'd7);
    checks++;
    if (carry_flag !== 1'b1) begin
      failures++;
      $display("FAIL shl_carry got carry=%b required 1", carry_flag);
    end
    exec_instr(OP_SHR,  3'd3, 3'd2);
  endtask

  task automatic test_branch();
    exec_instr(OP_MOVI, 3'd4, 3'd5);
    exec_instr(OP_BEQ,  3'd1, 3'd4);
    exec_instr(OP_BNE,  3'd1, 3'd4);
    exec_instr(OP_BEQ,  3'd1, 3'd2);
    exec_instr(OP_BNE,  3'd1, 3'd2);
  endtask

  task automatic test_cmp_hold();
    int accepts = 0;
    int dones   = 0;
    exec_instr(OP_MOVI, 3'd1, 3'd5);
    exec_instr(OP_MOVI, 3'd2, 3'd2);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {OP_CMP, 3'd1, 3'd2};
    for (int k = 0; k < 9; k++) begin
      if (bus.instr_ready === 1'b1) accepts++;
      if (done === 1'b1) dones++;
      if (k < 8) @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    m_e = 1'b0; m_z = 1'b0; m_p = 1'b0;   // 5 - 2 = 3
    checks++;
    if ({accepts, dones} !== {32'd3, 32'd3}) begin
      failures++;
      $display("FAIL cmp_hold_rate got accepts=%0d dones=%0d required 3 and 3", accepts, dones);
    end
    @(negedge clk);
    checks++;
    if ({eq_flag, zero_flag, pari_flag} !== 3'b000) begin
      failures++;
      $display("FAIL cmp_flags got eq=%b z=%b p=%b required 000", eq_flag, zero_flag, pari_flag);
    end
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== m_regs[i]) begin
        failures++;
        $display("FAIL cmp_no_write r%0d got %h required %h", i, dbg_data, m_regs[i]);
      end
    end
    $display("txn cmp held valid accepts=%0d dones=%0d", accepts, dones);
  endtask

  task automatic test_random();
    logic [3:0] ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                             4'h8, 4'h9, 4'hA, 4'hD, 4'hF};
    for (int n = 0; n < 40; n++) begin
      exec_instr(ops[$urandom_range(0, 12)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    exec_instr(OP_ADD, 3'd5, 3'd5);    // rd == rs reads the old value
  endtask

  task automatic test_illegal();
`ifdef ALU_CTRL_TRAP_EN
    exec_instr(4'b1100, 3'd1, 3'd2);
    repeat (3) @(negedge clk);
    checks++;
    if ({trap, bus.instr_ready} !== 2'b10) begin
      failures++;
      $display("FAIL trap_sticky got trap=%b rdy=%b required trap=1 rdy=0", trap, bus.instr_ready);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({trap, bus.instr_ready} !== 2'b01) begin
      failures++;
      $display("FAIL trap_clear got trap=%b rdy=%b required trap=0 rdy=1", trap, bus.instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
`else
    exec_instr(4'b1100, 3'd1, 3'd2);
    exec_instr(4'b1011, 3'd3, 3'd4);
    exec_instr(4'b1110, 3'd5, 3'd6);
    exec_instr(OP_NOP,  3'd2, 3'd1);
`endif
  endtask

  task automatic test_reset_mid_exec();
    exec_instr(OP_MOVI, 3'd5, 3'd6);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {OP_ADD, 3'd5, 3'd5};
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.alu_cmd !== OP_ADD) begin
      failures++;
      $display("FAIL abort_in_exec got cmd=%b required 0000", bus.alu_cmd);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.instr_ready, done, br_valid, br_taken, bus.alu_cmd, bus.alu_inA, bus.alu_inB, bus.alu_sc_i,
         eq_flag, zero_flag, pari_flag, carry_flag, trap}
        !== {1'b1, 3'b000, 4'hF, 16'h0000, 1'b0, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL abort_outputs got rdy=%b done=%b cmd=%b A=%h B=%h flags=%b%b%b%b trap=%b required rdy=1 cmd=1111 others 0",
               bus.instr_ready, done, bus.alu_cmd, bus.alu_inA, bus.alu_inB,
               eq_flag, zero_flag, pari_flag, carry_flag, trap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, done} !== 2'b10) begin
      failures++;
      $display("FAIL abort_idle got rdy=%b done=%b required rdy=1 done=0", bus.instr_ready, done);
    end
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        failures++;
        $display("FAIL abort_reg r%0d got %h required 00", i, dbg_data);
      end
    end
    $display("txn reset during EXEC of ADD r5,r5");
    exec_instr(OP_MOVI, 3'd5, 3'd1);
    exec_instr(OP_ADD,  3'd5, 3'd5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_branch();
    test_cmp_hold();
    test_random();
    test_illegal();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning number of internal 8-bit registers (power of 2, 2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr  input  10  [9:6] opcode, [5:3] rd, [2:0] rs or imm3.
REQ-006 SHALL have port instr_ready  output  1  instruction accepted when high with instr_valid.
REQ-007 SHALL have ports alu_cmd/alu_inA/alu_inB/alu_sc_i  output  4/8/8/1  ALU drive.
REQ-008 SHALL have ports alu_rslt/alu_sc_o/alu_pari/alu_zero/alu_equal  input  8/1/1/1/1  combinational ALU response.
REQ-009 SHALL have ports done, br_valid, br_taken  output  1 each  completion and branch result pulses.
REQ-010 SHALL have ports eq_flag, zero_flag, pari_flag, carry_flag  output  1 each  registered status.
REQ-011 SHALL have ports dbg_addr input 3, dbg_data output 8  combinational register read.
REQ-012 SHALL have port trap  output  1  sticky illegal-opcode indicator.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready=1 only in IDLE; handshake at edge with instr_valid&&instr_ready latches instr and enters EXEC.
REQ-014 SHALL in EXEC drive alu_cmd=opcode, alu_inA=R[rd], alu_inB=R[rs]; MOV: inA=R[rs]; ADDI: inB=imm3 zero-extended; MOVI: inA=imm3 zero-extended, inB=0.
REQ-015 SHALL drive alu_sc_i=carry_flag for SHL(0001)/SHR(0010), 0 otherwise; in IDLE/WB drive alu_cmd=1111, inA=inB=0.
REQ-016 SHALL capture alu_rslt, sc_o, pari, zero, equal at end of EXEC into holding registers; WB uses only captured values.
REQ-017 SHALL in WB write captured result to R[rd] for opcodes 0000-0111 and 1010; CMP(1101), BNE(1000), BEQ(1001), NOP(1111) write nothing.
REQ-018 SHALL in WB update zero/pari/eq flags for every writing opcode and CMP; carry_flag updated only by SHL/SHR; branches and NOP leave flags unchanged.
REQ-019 SHALL pulse done for exactly the WB cycle of every accepted instruction; latency accept-edge to done = 2 cycles; throughput one instruction per 3 cycles.
REQ-020 SHALL pulse br_valid in WB for BEQ/BNE with br_taken=captured equal (BEQ) or !equal (BNE); br_taken=0 whenever br_valid=0.
REQ-021 SHALL treat rd=rs in the same instruction as read-before-write (old value used, new value written).
REQ-022 SHALL return R[dbg_addr] on dbg_data combinationally, showing the new value from the edge ending WB onward; dbg_addr>=NREGS returns 0.
REQ-023 SHALL treat unlisted opcodes (1011,1100,1110) as illegal, handled per Configuration.
REQ-024 SHALL ignore instr_valid outside IDLE; instr need not be held after acceptance.

Reset
REQ-025 SHALL on rst_n=0 immediately force IDLE, all registers, flags, trap, done, br_valid, br_taken to 0, alu_cmd=1111, operands 0, instr_ready=1 once not in trap.
REQ-026 SHALL abort any in-flight instruction on reset mid-EXEC/WB with no register write.

Configuration
REQ-027 SHALL, with ALU_CTRL_TRAP_EN defined, on illegal opcode set trap at WB, pulse done, hold instr_ready=0 until reset; without it, illegal opcode executes as NOP and trap is tied 0.

Structure
REQ-028 SHALL take opcode enum, FSM state enum, instruction field widths and DATA_W=8 from shared package alu_pkg.
REQ-029 SHALL instantiate sub-module reg_file (NREGS x 8, two read ports, one write port, async reset).

Verification
REQ-030 MOVI r1,#3; MOVI r2,#2; ADD r1,r2 -> done 2 cycles after each accept, dbg r1=5, zero_flag=0.
REQ-031 MOVI r3,#4 (4=0000_0100); SHL r3,r2(=2) -> alu_cmd 0001 with inA=4, inB=2 in EXEC; dbg r3 = ALU result; carry_flag=captured sc_o.
REQ-032 r1=5, r4=5; BEQ r1,r4 -> br_valid=1, br_taken=1; BNE r1,r4 -> br_taken=0; no register changes.
REQ-033 CMP r1,r2 with 5 vs 2 -> eq_flag=0, no write; instr_valid held high during EXEC/WB -> only one accept per 3 cycles.
REQ-034 opcode 1100 -> with ALU_CTRL_TRAP_EN: trap=1, instr_ready stuck 0; without: done pulse, no state change.
REQ-035 rst_n low during EXEC of ADD -> target register unchanged, all outputs at reset values, IDLE next.
